lipsi_uart_tx: RTL and testbench



---
 rtl/lipsi_uart_tx.sv | 83 ++++++++
 tb/tb_lipsi_uart_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lipsi_uart_tx.sv
// rtl/lipsi_uart_tx.sv - 8N1/8N2 UART transmitter for the Lipsi output port
module lipsi_uart_tx #(
  parameter int CLK_DIV   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);
  // rst_n term keeps the producer stalled while the block is held in reset
  assign tx_ready = (state == IDLE) && ena && rst_n;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      txd     <= 1'b1;
      div_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (state == IDLE) begin
      if (tx_valid && tx_ready) begin
        shift   <= tx_data;
        state   <= START;
        div_cnt <= '0;
        bit_idx <= '0;
        txd     <= 1'b0;
      end
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      // txd is loaded with the level of the period that starts at the wrap
      if (div_wrap) begin
        case (state)
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            txd     <= shift[0];
          end
          DATA: begin
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= '0;
              txd     <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shift[1];
            end
          end
          STOP: begin
            if (bit_idx == STOP_LAST) begin
              state   <= IDLE;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lipsi_uart_tx.sv
// tb/tb_lipsi_uart_tx.sv - randomized self-checking bench for lipsi_uart_tx
module tb_lipsi_uart_tx;

  localparam int DIV0 = 16, SB0 = 1, L0 = (9 + SB0) * DIV0;
  localparam int DIV1 = 4,  SB1 = 2, L1 = (9 + SB1) * DIV1;

  logic       clk = 0, rst_n = 0, ena = 1;
  logic [7:0] tx_data0 = 0, tx_data1 = 0;
  logic       tx_valid0 = 0, tx_valid1 = 0;
  logic       tx_ready0, txd0, busy0, tx_ready1, txd1, busy1;

  int total = 0, bad = 0;
  logic q_txd[$];
  logic q_busy[$];

  always #5 clk = ~clk;

  lipsi_uart_tx #(.CLK_DIV(DIV0), .STOP_BITS(SB0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .txd(txd0), .busy(busy0));

  lipsi_uart_tx #(.CLK_DIV(DIV1), .STOP_BITS(SB1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .txd(txd1), .busy(busy1));

  // Reference line level: frame starting at `start` is 1 start, 8 data LSB first, sb stop bits
  function automatic int frame_err(input logic [7:0] b, input int div, input int sb,
                                   input int start, input int from, input int to);
    int err = 0;
    for (int k = from; k < to; k++) begin
      int j = k - start;
      logic el, eb;
      eb = (j >= 0) && (j < (9 + sb) * div);
      if (!eb)              el = 1'b1;
      else if (j / div == 0) el = 1'b0;
      else if (j / div <= 8) el = b[j / div - 1];
      else                   el = 1'b1;
      if (q_txd[k] !== el || q_busy[k] !== eb) err++;
    end
    return err;
  endfunction

  function automatic logic [7:0] decode(input int off, input int div);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = q_txd[off + (i + 1) * div + div / 2];
    return b;
  endfunction

  function automatic int count_busy();
    int c = 0;
    foreach (q_busy[i]) if (q_busy[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic launch(input bit which, input logic [7:0] b);
    @(negedge clk);
    if (which) begin tx_data1 = b; tx_valid1 = 1; end
    else       begin tx_data0 = b; tx_valid0 = 1; end
    #1;
    total++;
    if ((which ? tx_ready1 : tx_ready0) !== 1'b1) begin
      bad++; $display("FAIL launch_ready dut%0d: got %b want 1", which, which ? tx_ready1 : tx_ready0);
    end
    @(posedge clk);
  endtask

  task automatic capture(input bit which, input int n, input bit drop);
    q_txd.delete(); q_busy.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      q_txd.push_back(which ? txd1 : txd0);
      q_busy.push_back(which ? busy1 : busy0);
      if (i == 0 && drop) begin
        if (which) tx_valid1 = 0; else tx_valid0 = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; ena = 1; tx_valid0 = 1; tx_data0 = 8'h5A;
    repeat (5) @(negedge clk);
    total += 4;
    if (txd0 !== 1'b1)     begin bad++; $display("FAIL reset_txd: got %b want 1", txd0); end
    if (busy0 !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    if (tx_ready0 !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", tx_ready0); end
    if (txd1 !== 1'b1 || busy1 !== 1'b0) begin
      bad++; $display("FAIL reset_dut1: txd=%b busy=%b want 1/0", txd1, busy1);
    end
    tx_valid0 = 0; rst_n = 1; #1;
    total++;
    if (tx_ready0 !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", tx_ready0); end
  endtask

  task automatic test_single();
    logic [7:0] b;
    int e;
    for (int t = 0; t < 5; t++) begin
      b = (t == 0) ? 8'h55 : 8'($urandom);
      launch(0, b);
      capture(0, L0 + 2, 1);
      e = frame_err(b, DIV0, SB0, 0, 0, L0 + 2);
      total += 3;
      if (e !== 0) begin bad++; $display("FAIL single_wave %02h: %0d bad cycles, want 0", b, e); end
      if (count_busy() !== L0) begin bad++; $display("FAIL single_busy %02h: got %0d want %0d", b, count_busy(), L0); end
      if (decode(0, DIV0) !== b) begin bad++; $display("FAIL single_decode: got %02h want %02h", decode(0, DIV0), b); end
    end
  endtask

  task automatic test_back_to_back();
    int acc_k = -1, n = 2 * L0 + 4, e;
    @(negedge clk); tx_data0 = 8'hA3; tx_valid0 = 1;
    @(posedge clk);
    q_txd.delete(); q_busy.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      q_txd.push_back(txd0); q_busy.push_back(busy0);
      if (k == 0) tx_data0 = 8'h0F;
      if (acc_k >= 0) tx_valid0 = 0;
      else if (tx_valid0 && tx_ready0) acc_k = k;
    end
    // the single IDLE cycle at L0 is the accept cycle; frame 2 starts right after
    e = frame_err(8'hA3, DIV0, SB0, 0, 0, L0 + 1) + frame_err(8'h0F, DIV0, SB0, L0 + 1, L0 + 1, n);
    total += 4;
    if (acc_k !== L0) begin bad++; $display("FAIL b2b_accept_cycle: got %0d want %0d", acc_k, L0); end
    if (e !== 0) begin bad++; $display("FAIL b2b_wave: %0d bad cycles, want 0", e); end
    if (decode(0, DIV0) !== 8'hA3) begin bad++; $display("FAIL b2b_decode1: got %02h want a3", decode(0, DIV0)); end
    if (decode(L0 + 1, DIV0) !== 8'h0F) begin bad++; $display("FAIL b2b_decode2: got %02h want 0f", decode(L0 + 1, DIV0)); end
  endtask

  task automatic test_stop2();
    logic [7:0] b;
    int e, lows;
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 8'hFF : 8'($urandom);
      launch(1, b);
      capture(1, L1 + 4, 1);
      e = frame_err(b, DIV1, SB1, 0, 0, L1 + 4);
      lows = 0;
      foreach (q_txd[i]) if (q_txd[i] === 1'b0) lows++;
      total += 3;
      if (e !== 0) begin bad++; $display("FAIL stop2_wave %02h: %0d bad cycles, want 0", b, e); end
      if (count_busy() !== L1) begin bad++; $display("FAIL stop2_busy %02h: got %0d want %0d", b, count_busy(), L1); end
      if (t == 0 && lows !== DIV1) begin bad++; $display("FAIL stop2_ff_lows: got %0d want %0d", lows, DIV1); end
      if (t != 0 && decode(0, DIV1) !== b) begin bad++; $display("FAIL stop2_decode: got %02h want %02h", decode(0, DIV1), b); end
    end
  endtask

  task automatic test_ena();
    logic [7:0] nb = 8'($urandom);
    int n = L0 + 12, e, rdy_err = 0;
    launch(0, 8'h81);
    q_txd.delete(); q_busy.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      q_txd.push_back(txd0); q_busy.push_back(busy0);
      if (k >= L0 && tx_ready0 !== 1'b0) rdy_err++;
      if (k == 0) tx_valid0 = 0;
      if (k == 50) begin ena = 0; tx_data0 = nb; tx_valid0 = 1; end
    end
    e = frame_err(8'h81, DIV0, SB0, 0, 0, n);
    total += 2;
    if (e !== 0) begin bad++; $display("FAIL ena_wave: %0d bad cycles, want 0", e); end
    if (rdy_err !== 0) begin bad++; $display("FAIL ena_blocked_ready: %0d cycles ready, want 0", rdy_err); end
    @(negedge clk); ena = 1; #1;
    total++;
    if (tx_ready0 !== 1'b1) begin bad++; $display("FAIL ena_return_ready: got %b want 1", tx_ready0); end
    @(posedge clk);
    capture(0, L0 + 2, 1);
    e = frame_err(nb, DIV0, SB0, 0, 0, L0 + 2);
    total += 1;
    if (e !== 0 || decode(0, DIV0) !== nb) begin
      bad++; $display("FAIL ena_pending_byte: got %02h (%0d bad cycles) want %02h", decode(0, DIV0), e, nb);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int cut, e, junk;
    for (int t = 0; t < 2; t++) begin
      b   = (t == 0) ? 8'h3C : 8'($urandom);
      cut = (t == 0) ? 70 : int'($urandom_range(1, DIV0 - 1));
      launch(0, b);
      q_txd.delete(); q_busy.delete();
      for (int k = 0; k <= cut; k++) begin
        @(negedge clk);
        q_txd.push_back(txd0); q_busy.push_back(busy0);
        if (k == 0) tx_valid0 = 0;
      end
      e = frame_err(b, DIV0, SB0, 0, 0, cut + 1);
      rst_n = 0; #1;
      total += 2;
      if (e !== 0) begin bad++; $display("FAIL rstmid_pre_wave %02h: %0d bad cycles, want 0", b, e); end
      if (txd0 !== 1'b1 || busy0 !== 1'b0) begin
        bad++; $display("FAIL rstmid_async: txd=%b busy=%b want 1/0", txd0, busy0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1;
      capture(0, L0 + 5, 0);
      junk = 0;
      foreach (q_txd[i]) if (q_txd[i] !== 1'b1 || q_busy[i] !== 1'b0) junk++;
      total++;
      if (junk !== 0) begin bad++; $display("FAIL rstmid_no_resume: %0d active cycles, want 0", junk); end
    end
    launch(0, 8'hC3);
    capture(0, L0 + 2, 1);
    e = frame_err(8'hC3, DIV0, SB0, 0, 0, L0 + 2);
    total++;
    if (e !== 0 || decode(0, DIV0) !== 8'hC3) begin
      bad++; $display("FAIL rstmid_after: got %02h (%0d bad cycles) want c3", decode(0, DIV0), e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stop2();
    test_ena();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
